// File: rtl/otter_hazard_unit_pkg.sv
// ---------------------------------------------------------------------------
// otter_hazard_unit_pkg
//   Shared types for the OTTER hazard/forwarding controller:
//     opcode_t     - RV32I major opcodes seen by the OTTER decoder
//     hz_entry_t   - one in-flight instruction slot {valid, rd, reg_write, is_load}
//     fwd_sel_w()  - width of a forward select able to encode 0..DEPTH
// ---------------------------------------------------------------------------
package otter_hazard_unit_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011,
    OP_SYS    = 7'b1110011
  } opcode_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  is_load;
  } hz_entry_t;

  // Select value 0 means "register file", 1..DEPTH name a tracked stage.
  function automatic int fwd_sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/otter_hazard_unit_fwd_match.sv
// ---------------------------------------------------------------------------
// otter_hazard_unit_fwd_match
//   Priority matcher for one source operand against the in-flight tracker.
//   The lowest-numbered (youngest) matching stage wins, since it holds the
//   most recent value of the register.
// Ports
//   entries_i  in  tracker contents, index 0 = stage 1 (EX)
//   rs_i       in  source register address of the DE instruction
//   used_i     in  operand is actually read by the DE instruction
//   hit_o      out some stage matches
//   stage_o    out 1-based stage number of the nearest match (0 if none)
//   load_o     out the nearest matching producer is a load
// ---------------------------------------------------------------------------
module otter_hazard_unit_fwd_match
  import otter_hazard_unit_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int SEL_W = fwd_sel_w(DEPTH)
) (
  input  hz_entry_t [DEPTH-1:0]      entries_i,
  input  logic      [REG_ADDR_W-1:0] rs_i,
  input  logic                       used_i,
  output logic                       hit_o,
  output logic      [SEL_W-1:0]      stage_o,
  output logic                       load_o
);

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    hit_o   = 1'b0;
    stage_o = '0;
    load_o  = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (entries_i[i].valid && entries_i[i].reg_write &&
          (entries_i[i].rd == rs_i) && (rs_i != '0) && used_i) begin
        hit_o   = 1'b1;
        stage_o = SEL_W'(i + 1);
        load_o  = entries_i[i].is_load;
      end
    end
  end

endmodule

// File: rtl/otter_hazard_unit.sv
// ---------------------------------------------------------------------------
// otter_hazard_unit
//   Hazard / forwarding controller for the pipelined OTTER MCU. Tracks the
//   instructions in flight from EX to WB, detects RAW hazards for the DE
//   instruction, registers forward selects for the EX stage, stalls on
//   load-use and flushes the front end on an EX redirect.
//
//   Optional feature: define OTTER_HAZARD_PERF_EN to build saturating
//   stall/flush cycle counters; otherwise STALL_CNT/FLUSH_CNT read 0.
//
// Ports
//   CLK, RESET_N            clock, asynchronous active-low reset
//   DE_VALID                DE holds a real instruction
//   DE_RS1/DE_RS2           source registers, DE_RS1_USED/DE_RS2_USED qualify them
//   DE_RD, DE_REG_WRITE     destination of the DE instruction
//   DE_IS_LOAD              DE instruction is a load
//   EX_REDIRECT             control transfer resolved in EX
//   STALL                   hold PC, IF/ID and DE this cycle
//   FLUSH                   kill IF/ID and DE contents
//   STG_VALID               valid bit per tracked stage, bit 0 = EX
//   FWD_A_SEL/FWD_B_SEL     EX operand source: 0 = RF/DE, k = stage k result
//   STALL_CNT/FLUSH_CNT     performance counters
// ---------------------------------------------------------------------------
module otter_hazard_unit
  import otter_hazard_unit_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 3,
  parameter int CNT_W      = 32
) (
  input  logic                        CLK,
  input  logic                        RESET_N,
  input  logic                        DE_VALID,
  input  logic [REG_ADDR_W-1:0]       DE_RS1,
  input  logic [REG_ADDR_W-1:0]       DE_RS2,
  input  logic                        DE_RS1_USED,
  input  logic                        DE_RS2_USED,
  input  logic [REG_ADDR_W-1:0]       DE_RD,
  input  logic                        DE_REG_WRITE,
  input  logic                        DE_IS_LOAD,
  input  logic                        EX_REDIRECT,
  output logic                        STALL,
  output logic                        FLUSH,
  output logic [DEPTH-1:0]            STG_VALID,
  output logic [fwd_sel_w(DEPTH)-1:0] FWD_A_SEL,
  output logic [fwd_sel_w(DEPTH)-1:0] FWD_B_SEL,
  output logic [CNT_W-1:0]            STALL_CNT,
  output logic [CNT_W-1:0]            FLUSH_CNT
);

  localparam int SEL_W = fwd_sel_w(DEPTH);
  // A load at stage k stalls when k+1 < LOAD_STAGE, i.e. k < LOAD_STAGE-1.
  localparam logic [SEL_W-1:0] LU_LIMIT  = SEL_W'(LOAD_STAGE - 1);
  localparam logic [SEL_W-1:0] SEL_DEPTH = SEL_W'(DEPTH);

  hz_entry_t [DEPTH-1:0] ent_q, ent_d;
  logic [SEL_W-1:0]      fwd_a_q, fwd_a_d;
  logic [SEL_W-1:0]      fwd_b_q, fwd_b_d;

  logic                  hit_a, hit_b;
  logic                  load_a, load_b;
  logic [SEL_W-1:0]      stage_a, stage_b;
  logic                  lu_a, lu_b;
  logic                  accept;

  otter_hazard_unit_fwd_match #(
    .DEPTH (DEPTH),
    .SEL_W (SEL_W)
  ) u_match_a (
    .entries_i (ent_q),
    .rs_i      (DE_RS1),
    .used_i    (DE_RS1_USED),
    .hit_o     (hit_a),
    .stage_o   (stage_a),
    .load_o    (load_a)
  );

  otter_hazard_unit_fwd_match #(
    .DEPTH (DEPTH),
    .SEL_W (SEL_W)
  ) u_match_b (
    .entries_i (ent_q),
    .rs_i      (DE_RS2),
    .used_i    (DE_RS2_USED),
    .hit_o     (hit_b),
    .stage_o   (stage_b),
    .load_o    (load_b)
  );

  // Load data not yet forwardable: the consumer must wait in DE.
  assign lu_a = hit_a & load_a & (stage_a < LU_LIMIT);
  assign lu_b = hit_b & load_b & (stage_b < LU_LIMIT);

  // A redirect kills the DE instruction anyway, so it never stalls.
  assign STALL  = DE_VALID & ~EX_REDIRECT & (lu_a | lu_b);
  assign FLUSH  = EX_REDIRECT;
  assign accept = DE_VALID & ~STALL & ~EX_REDIRECT;

  always_comb begin
    ent_d = '0;
    if (accept) begin
      ent_d[0] = '{valid: 1'b1, rd: DE_RD, reg_write: DE_REG_WRITE,
                   is_load: DE_IS_LOAD};
    end
    for (int i = 1; i < DEPTH; i++) begin
      ent_d[i] = ent_q[i-1];
    end

    // Producers shift one stage at this edge, hence k+1. A producer already
    // at the last stage retires now and the write-first RF supplies it.
    fwd_a_d = '0;
    fwd_b_d = '0;
    if (accept && hit_a && (stage_a < SEL_DEPTH)) begin
      fwd_a_d = stage_a + SEL_W'(1);
    end
    if (accept && hit_b && (stage_b < SEL_DEPTH)) begin
      fwd_b_d = stage_b + SEL_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ent_q   <= '0;
      fwd_a_q <= '0;
      fwd_b_q <= '0;
    end else begin
      ent_q   <= ent_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  always_comb begin
    STG_VALID = '0;
    for (int i = 0; i < DEPTH; i++) begin
      STG_VALID[i] = ent_q[i].valid;
    end
  end

  assign FWD_A_SEL = fwd_a_q;
  assign FWD_B_SEL = fwd_b_q;

`ifdef OTTER_HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (STALL) begin
        stall_cnt_q <= sat_inc(stall_cnt_q);
      end
      if (FLUSH) begin
        flush_cnt_q <= sat_inc(flush_cnt_q);
      end
    end
  end

  assign STALL_CNT = stall_cnt_q;
  assign FLUSH_CNT = flush_cnt_q;
`else
  assign STALL_CNT = '0;
  assign FLUSH_CNT = '0;
`endif

endmodule

// File: tb/tb_otter_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_otter_hazard_unit
//   Directed stimulus with hand-computed expectations. The driver pushes the
//   expected outputs for each cycle into a queue; a monitor on the falling
//   edge pops and compares whatever the DUT presents.
// ---------------------------------------------------------------------------
module tb_otter_hazard_unit;

`ifdef OTTER_HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        DE_VALID = 1'b0;
  logic [4:0]  DE_RS1 = '0, DE_RS2 = '0, DE_RD = '0;
  logic        DE_RS1_USED = 1'b0, DE_RS2_USED = 1'b0;
  logic        DE_REG_WRITE = 1'b0, DE_IS_LOAD = 1'b0, EX_REDIRECT = 1'b0;
  logic        STALL, FLUSH;
  logic [2:0]  STG_VALID;
  logic [1:0]  FWD_A_SEL, FWD_B_SEL;
  logic [31:0] STALL_CNT, FLUSH_CNT;

  always #5 CLK = ~CLK;

  otter_hazard_unit dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .DE_VALID     (DE_VALID),
    .DE_RS1       (DE_RS1),
    .DE_RS2       (DE_RS2),
    .DE_RS1_USED  (DE_RS1_USED),
    .DE_RS2_USED  (DE_RS2_USED),
    .DE_RD        (DE_RD),
    .DE_REG_WRITE (DE_REG_WRITE),
    .DE_IS_LOAD   (DE_IS_LOAD),
    .EX_REDIRECT  (EX_REDIRECT),
    .STALL        (STALL),
    .FLUSH        (FLUSH),
    .STG_VALID    (STG_VALID),
    .FWD_A_SEL    (FWD_A_SEL),
    .FWD_B_SEL    (FWD_B_SEL),
    .STALL_CNT    (STALL_CNT),
    .FLUSH_CNT    (FLUSH_CNT)
  );

  typedef struct {
    string       nm;
    logic        stall;
    logic        flush;
    logic [2:0]  stg;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int unsigned sc_m = 0;
  int unsigned fc_m = 0;

  task automatic chk(input string nm, input string fld,
                     input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s.%s actual=%0h expected=%0h", nm, fld, act, expv);
    end
  endtask

  // Monitor: compare the DUT against the oldest pending expectation.
  initial begin
    forever begin
      @(negedge CLK);
      if (q.size() != 0) begin
        exp_t r;
        r = q.pop_front();
        chk(r.nm, "STALL",     32'(STALL),     32'(r.stall));
        chk(r.nm, "FLUSH",     32'(FLUSH),     32'(r.flush));
        chk(r.nm, "STG_VALID", 32'(STG_VALID), 32'(r.stg));
        chk(r.nm, "FWD_A_SEL", 32'(FWD_A_SEL), 32'(r.fa));
        chk(r.nm, "FWD_B_SEL", 32'(FWD_B_SEL), 32'(r.fb));
        chk(r.nm, "STALL_CNT", STALL_CNT,      r.sc);
        chk(r.nm, "FLUSH_CNT", FLUSH_CNT,      r.fc);
      end
    end
  end

  // One cycle: drive DE/redirect, record expected outputs for this cycle.
  task automatic step(input string nm, input logic v,
                      input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2,
                      input logic [4:0] rd, input logic rw, input logic ld,
                      input logic rdr, input logic es, input logic ef,
                      input logic [2:0] estg, input logic [1:0] efa,
                      input logic [1:0] efb);
    exp_t r;
    @(posedge CLK);
    #1;
    DE_VALID     = v;
    DE_RS1       = rs1;
    DE_RS1_USED  = u1;
    DE_RS2       = rs2;
    DE_RS2_USED  = u2;
    DE_RD        = rd;
    DE_REG_WRITE = rw;
    DE_IS_LOAD   = ld;
    EX_REDIRECT  = rdr;
    r.nm    = nm;
    r.stall = es;
    r.flush = ef;
    r.stg   = estg;
    r.fa    = efa;
    r.fb    = efb;
    r.sc    = PERF ? 32'(sc_m) : 32'd0;
    r.fc    = PERF ? 32'(fc_m) : 32'd0;
    q.push_back(r);
    sc_m += 32'(es);
    fc_m += 32'(ef);
  endtask

  task automatic idle(input string nm, input logic [2:0] estg,
                      input logic [1:0] efa, input logic [1:0] efb);
    step(nm, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, estg, efa, efb);
  endtask

  // Idle cycle that changes RESET_N mid-cycle; everything must read zero.
  task automatic reset_step(input string nm, input logic lvl);
    exp_t r;
    @(posedge CLK);
    #1;
    DE_VALID    = 1'b0;
    DE_RS1      = '0;
    DE_RS2      = '0;
    DE_RS1_USED = 1'b0;
    DE_RS2_USED = 1'b0;
    DE_RD       = '0;
    DE_REG_WRITE = 1'b0;
    DE_IS_LOAD  = 1'b0;
    EX_REDIRECT = 1'b0;
    sc_m = 0;
    fc_m = 0;
    r.nm = nm;
    r.stall = 1'b0;
    r.flush = 1'b0;
    r.stg = '0;
    r.fa = '0;
    r.fb = '0;
    r.sc = '0;
    r.fc = '0;
    q.push_back(r);
    #1;
    RESET_N = lvl;
  endtask

  // lw x5,0(x1) ; add x6,x5,x5 -> one stall, then both operands from stage 3.
  task automatic lu_seq(input string p);
    step({p, "_lw"},     1, 1, 1, 0, 0, 5, 1, 1, 0, 0, 0, 3'b000, 0, 0);
    step({p, "_stall"},  1, 5, 1, 5, 1, 6, 1, 0, 0, 1, 0, 3'b001, 0, 0);
    step({p, "_accept"}, 1, 5, 1, 5, 1, 6, 1, 0, 0, 0, 0, 3'b010, 0, 0);
    idle({p, "_fwd3"},  3'b101, 3, 3);
    idle({p, "_d1"},    3'b010, 0, 0);
    idle({p, "_d2"},    3'b100, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_step("rst_hold", 1'b0);
    reset_step("rst_rel",  1'b1);

    // 1: back-to-back ALU dependency forwards from MEM.
    step("t1_add_x5", 1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 3'b000, 0, 0);
    step("t1_add_x6", 1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0, 3'b001, 0, 0);
    idle("t1_fwdA2", 3'b011, 2, 0);
    idle("t1_d1",    3'b110, 0, 0);
    idle("t1_d2",    3'b100, 0, 0);

    // 2: one-nop gap forwards from WB; two-nop gap reads the RF.
    step("t2_add_x5",  1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 3'b000, 0, 0);
    step("t2_nop",     1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 3'b001, 0, 0);
    step("t2_sub",     1, 1, 1, 5, 1, 7, 1, 0, 0, 0, 0, 3'b011, 0, 0);
    step("t2_fwdB3",   1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0, 3'b111, 0, 3);
    step("t2_nop1",    1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 3'b111, 0, 0);
    step("t2_nop2",    1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 3'b111, 0, 0);
    step("t2_sub2",    1, 1, 1, 5, 1, 7, 1, 0, 0, 0, 0, 3'b111, 0, 0);
    idle("t2_fwdB0", 3'b111, 0, 0);
    idle("t2_d1",    3'b110, 0, 0);
    idle("t2_d2",    3'b100, 0, 0);

    // 3: load-use.
    lu_seq("t3");

    // 4: load-use coinciding with a redirect: flush wins, no stall.
    step("t4_lw",    1, 1, 1, 0, 0, 5, 1, 1, 0, 0, 0, 3'b000, 0, 0);
    step("t4_redir", 1, 5, 1, 5, 1, 6, 1, 0, 1, 0, 1, 3'b001, 0, 0);
    idle("t4_bubble", 3'b010, 0, 0);
    idle("t4_d1",     3'b100, 0, 0);

    // 5: x0 never hazards; an unused operand never hazards.
    step("t5_lw_x0",   1, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 3'b000, 0, 0);
    step("t5_use_x0",  1, 0, 1, 0, 0, 6, 1, 1, 0, 0, 0, 3'b001, 0, 0);
    step("t5_rs2_off", 1, 1, 1, 6, 0, 7, 1, 0, 0, 0, 0, 3'b011, 0, 0);
    idle("t5_d0", 3'b111, 0, 0);
    idle("t5_d1", 3'b110, 0, 0);
    idle("t5_d2", 3'b100, 0, 0);

    // 6: asynchronous reset mid-run, then counters from a clean start.
    step("t6_lw",     1, 1, 1, 0, 0, 5, 1, 1, 0, 0, 0, 3'b000, 0, 0);
    step("t6_stall",  1, 5, 1, 5, 1, 6, 1, 0, 0, 1, 0, 3'b001, 0, 0);
    step("t6_accept", 1, 5, 1, 5, 1, 6, 1, 0, 0, 0, 0, 3'b010, 0, 0);
    idle("t6_fwd3", 3'b101, 3, 3);
    reset_step("t6_async_rst", 1'b0);
    reset_step("t6_rst_rel",   1'b1);
    step("t6_post_rst", 1, 5, 1, 5, 1, 6, 1, 0, 0, 0, 0, 3'b000, 0, 0);
    idle("t6_p1", 3'b001, 0, 0);
    idle("t6_p2", 3'b010, 0, 0);
    idle("t6_p3", 3'b100, 0, 0);
    for (int i = 0; i < 3; i++) begin
      lu_seq($sformatf("t6_lu%0d", i));
    end
    step("t6_flush0", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 3'b000, 0, 0);
    step("t6_flush1", 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 3'b000, 0, 0);
    idle("t6_counts", 3'b000, 0, 0);

    repeat (2) @(posedge CLK);
    chk("drain", "pending", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
